// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types, segment patterns and decode helper for contador_display
//   disp_state_t : conversion FSM states
//   SEG_*        : active-low {g,f,e,d,c,b,a} patterns, SEG_BLANK turns every segment off
//   seg_decode   : BCD nibble to segment pattern, non-decimal nibbles blank
package contador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } disp_state_t;

    localparam int BCD_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 3-digit BCD converter
//   clk, reset : clock, asynchronous active-high reset
//   start      : request a conversion of bin (honoured only while idle)
//   bin [N]    : value to convert
//   bcd [12]   : last completed conversion, hundreds/tens/units
//   busy       : conversion in progress
module bin2bcd_seq
    import contador_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] bin,
    output logic [11:0]  bcd,
    output logic         busy
);

    localparam int IW = $clog2(N + 1);

    disp_state_t state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [11:0]   adj;
    logic [11:0]   stepped;

    always_comb begin
        // add-3 correction on every nibble that would overflow a decimal digit after doubling
        adj = scratch_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        stepped = (adj << 1) | {11'b0, sr_q[N-1]};

        state_d   = state_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = bin;
                    scratch_d = '0;
                    iter_d    = IW'(N);
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = stepped;
                sr_d      = sr_q << 1;
                iter_d    = iter_q - IW'(1);
                // only the final step publishes, so bcd never shows a partial result
                if (iter_q == IW'(1)) begin
                    bcd_d   = stepped;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = (state_q == CONV);

endmodule

// File: rtl/contador_display.sv
// rtl/contador_display.sv - counter value to multiplexed 3-digit common-anode 7-segment display
//   clk, reset : clock, asynchronous active-high reset
//   bin [N]    : binary value from the contador counter
//   bcd [12]   : last completed BCD conversion
//   busy       : conversion in progress
//   an [3]     : active-low digit enables, bit 0 = units
//   seg [7]    : active-low segments {g,f,e,d,c,b,a}, leading zeros blanked
module contador_display
    import contador_pkg::*;
#(
    parameter int N           = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] bin,
    output logic [11:0]  bcd,
    output logic         busy,
    output logic [2:0]   an,
    output logic [6:0]   seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [N-1:0]  last_bin_q, last_bin_d;
    logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic          start;
    logic          wrap;
    logic [3:0]    hund, tens, units;

    // a change arriving mid-conversion stays pending until the converter is idle again
    assign start = (bin != last_bin_q) && !busy;
    assign wrap  = (refresh_cnt_q == CW'(REFRESH_DIV - 1));

    bin2bcd_seq #(
        .N (N)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy)
    );

    always_comb begin
        last_bin_d    = start ? bin : last_bin_q;
        refresh_cnt_d = wrap ? '0 : refresh_cnt_q + CW'(1);
        digit_idx_d   = digit_idx_q;
        if (wrap) begin
            digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_bin_q    <= '0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
        end else begin
            last_bin_q    <= last_bin_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    assign hund  = bcd[11:8];
    assign tens  = bcd[7:4];
    assign units = bcd[3:0];

    always_comb begin
        an  = 3'b111;
        seg = SEG_BLANK;
        case (digit_idx_q)
            2'd0: begin
                an  = 3'b110;
                seg = seg_decode(units);
            end
            2'd1: begin
                an  = 3'b101;
                seg = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
            end
            2'd2: begin
                an  = 3'b011;
                seg = (hund == 4'd0) ? SEG_BLANK : seg_decode(hund);
            end
            default: begin
                an  = 3'b111;
                seg = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_contador_display.sv
// tb/tb_contador_display.sv - self-checking bench for contador_display at N=6 and N=8
module tb_contador_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  bin6;
    logic [7:0]  bin8;
    logic [11:0] bcd6, bcd8;
    logic        busy6, busy8;
    logic [2:0]  an6, an8;
    logic [6:0]  seg6, seg8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    contador_display #(.N(6), .REFRESH_DIV(RD)) dut6 (
        .clk (clk), .reset (reset), .bin (bin6),
        .bcd (bcd6), .busy (busy6), .an (an6), .seg (seg6)
    );

    contador_display #(.N(8), .REFRESH_DIV(RD)) dut8 (
        .clk (clk), .reset (reset), .bin (bin8),
        .bcd (bcd8), .busy (busy8), .an (an8), .seg (seg8)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'b1111111;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int exp_an(input int d);
        return 7 & ~(1 << d);
    endfunction

    function automatic int exp_seg(input int v, input int d);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (d == 0) return int'(seg_tab[u]);
        if (d == 1) return (h == 0 && t == 0) ? int'(BLANK) : int'(seg_tab[t]);
        return (h == 0) ? int'(BLANK) : int'(seg_tab[h]);
    endfunction

    function automatic int bin_of(input int i);
        return (i == 0) ? int'(bin6) : int'(bin8);
    endfunction

    function automatic int width_of(input int i);
        return (i == 0) ? 6 : 8;
    endfunction

    // Model: a conversion of the latched value completes N+1 edges after the change is seen;
    // the display shows the decimal digits of the last completed value.
    int m_left [2];
    int m_last [2];
    int m_val  [2];
    int m_dec  [2];
    int m_cyc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_last[i] <= 0;
                m_val[i]  <= 0;
                m_dec[i]  <= 0;
            end
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_left[i] == 0) begin
                    if (bin_of(i) != m_last[i]) begin
                        m_last[i] <= bin_of(i);
                        m_val[i]  <= bin_of(i);
                        m_left[i] <= width_of(i);
                    end
                end else begin
                    if (m_left[i] == 1) m_dec[i] <= m_val[i];
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_bcd6",  int'(bcd6),  to_bcd(m_dec[0]));
            check("cmp_busy6", int'(busy6), int'(m_left[0] != 0));
            check("cmp_an6",   int'(an6),   exp_an((m_cyc / RD) % 3));
            check("cmp_seg6",  int'(seg6),  exp_seg(m_dec[0], (m_cyc / RD) % 3));
            check("cmp_bcd8",  int'(bcd8),  to_bcd(m_dec[1]));
            check("cmp_busy8", int'(busy8), int'(m_left[1] != 0));
            check("cmp_an8",   int'(an8),   exp_an((m_cyc / RD) % 3));
            check("cmp_seg8",  int'(seg8),  exp_seg(m_dec[1], (m_cyc / RD) % 3));
        end
    end

    // records every distinct bcd6 value and busy-low gaps while a restart is under test
    logic        rec_on  = 1'b0;
    logic        seen_hi = 1'b0;
    int          lowgap  = 0;
    logic [11:0] prev6   = 12'h000;
    logic [11:0] seq [$];

    always @(negedge clk) begin
        if (rec_on) begin
            if (bcd6 != prev6) seq.push_back(bcd6);
            prev6 <= bcd6;
            if (busy6) seen_hi <= 1'b1;
            else if (seen_hi && bcd6 != 12'h010) lowgap <= lowgap + 1;
        end
    end

    task automatic scan(input int which, input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh);
        int c0, c1, c2;
        logic [2:0] a;
        logic [6:0] s;
        c0 = 0; c1 = 0; c2 = 0;
        repeat (3 * RD) begin
            @(negedge clk);
            a = (which != 0) ? an8 : an6;
            s = (which != 0) ? seg8 : seg6;
            case (a)
                3'b110:  begin c0++; check("scan_units", int'(s), int'(su)); end
                3'b101:  begin c1++; check("scan_tens", int'(s), int'(st)); end
                3'b011:  begin c2++; check("scan_hund", int'(s), int'(sh)); end
                default: check("scan_an_onehot", int'(a), 3'b110);
            endcase
        end
        check("dwell_units", c0, RD);
        check("dwell_tens",  c1, RD);
        check("dwell_hund",  c2, RD);
    endtask

    initial begin
        int c6, c8;
        reset = 1'b1;
        bin6  = '0;
        bin8  = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd6",  int'(bcd6),  12'h000);
        check("rst_busy6", int'(busy6), 0);
        check("rst_an6",   int'(an6),   3'b110);
        check("rst_seg6",  int'(seg6),  7'b1000000);
        check("rst_bcd8",  int'(bcd8),  12'h000);
        check("rst_an8",   int'(an8),   3'b110);
        reset = 1'b0;

        c6 = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy6 || busy8) c6++;
        end
        check("no_busy_after_reset", c6, 0);

        // change mid-conversion: 63, then 10 two edges later
        rec_on = 1'b1;
        bin6 = 6'd63;
        repeat (2) @(negedge clk);
        bin6 = 6'd10;
        repeat (30) @(negedge clk);
        rec_on = 1'b0;
        check("restart_seq_len", seq.size(), 2);
        if (seq.size() >= 1) check("restart_seq0", int'(seq[0]), 12'h063);
        if (seq.size() >= 2) check("restart_seq1", int'(seq[1]), 12'h010);
        check("restart_gap_le1", int'(lowgap <= 1), 1);

        // clean restart, then busy duration for both widths
        bin6 = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bin6 = 6'd63;
        bin8 = 8'd255;
        c6 = 0;
        c8 = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy6) c6++;
            if (busy8) c8++;
        end
        check("busy_len6", c6, 6);
        check("busy_len8", c8, 8);
        check("conv_63",  int'(bcd6), 12'h063);
        check("conv_255", int'(bcd8), 12'h255);

        scan(0, 7'b0110000, 7'b0000010, BLANK);

        bin6 = 6'd5;
        repeat (20) @(negedge clk);
        check("conv_5", int'(bcd6), 12'h005);
        scan(0, 7'b0010010, BLANK, BLANK);

        bin8 = 8'd100;
        repeat (20) @(negedge clk);
        check("conv_100", int'(bcd8), 12'h100);
        scan(1, 7'b1000000, 7'b1000000, 7'b1111001);

        // reset during the third CONV cycle clears busy and bcd before the next edge
        bin6 = 6'd63;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", int'(busy6), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy6", int'(busy6), 0);
        check("abort_bcd6",  int'(bcd6),  12'h000);
        check("abort_bcd8",  int'(bcd8),  12'h000);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("after_abort_63", int'(bcd6), 12'h063);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
